// File: rtl/addmul_seq_unit.sv
// Sequential unsigned add/multiply unit with valid/ready on both sides.
// Add completes in one cycle; multiply retires STEP multiplier bits per cycle.
module addmul_seq_unit #(
  parameter int WIDTH = 32,
  parameter int RES_W = 40,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             Sel,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [RES_W-1:0] Result,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int N     = WIDTH / STEP;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);

  if ((WIDTH % STEP) != 0) begin : g_bad_step
    $error("addmul_seq_unit: STEP (%0d) must divide WIDTH (%0d)", STEP, WIDTH);
  end
  if ((RES_W < WIDTH + 1) || (RES_W > 2 * WIDTH)) begin : g_bad_res_w
    $error("addmul_seq_unit: RES_W (%0d) must lie in [WIDTH+1, 2*WIDTH]", RES_W);
  end

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RES_W-1:0]       result_q, result_d;
  logic                   ovf_q, ovf_d;

  logic                   accept;
  logic [WIDTH:0]         addSum;
  logic [2*WIDTH-1:0]     partial;
  logic [2*WIDTH-1:0]     accNext;

  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign ovf       = ovf_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // The multiplicand is pre-shifted each cycle, so the partial product only
  // needs the low STEP multiplier bits.
  always_comb begin
    addSum  = {1'b0, A} + {1'b0, B};
    partial = '0;
    for (int j = 0; j < STEP; j++) begin
      if (mplier_q[j]) begin
        partial = partial + (mcand_q << j);
      end
    end
    accNext = acc_q + partial;
  end

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE: begin
      end
      MUL: begin
        acc_d    = accNext;
        mcand_d  = mcand_q << STEP;
        mplier_d = mplier_q >> STEP;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          state_d  = DONE;
          result_d = accNext[RES_W-1:0];
          ovf_d    = ((accNext >> RES_W) != '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A new operation may start from IDLE or while the old result retires.
    if (accept) begin
      if (Sel) begin
        state_d  = MUL;
        mcand_d  = {{WIDTH{1'b0}}, A};
        mplier_d = B;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        state_d  = DONE;
        result_d = RES_W'(addSum);
        ovf_d    = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_addmul_seq_unit.sv
// Directed self-checking bench for addmul_seq_unit (WIDTH=32, RES_W=40, STEP=1).
module tb_addmul_seq_unit;

  localparam int WIDTH = 32;
  localparam int RES_W = 40;
  localparam int STEP  = 1;

  logic             clk;
  logic             nrst;
  logic             Sel;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] Result;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  int total;
  int bad;

  addmul_seq_unit #(
    .WIDTH(WIDTH),
    .RES_W(RES_W),
    .STEP (STEP)
  ) dut (
    .clk      (clk),
    .nrst     (nrst),
    .Sel      (Sel),
    .A        (A),
    .B        (B),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .Result   (Result),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one operation for a single edge, then scrambles the inputs so a
  // design that fails to register them on accept gets caught.
  task automatic applyStimulus(input logic sel, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b);
    Sel      = sel;
    A        = a;
    B        = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    Sel      = ~sel;
    A        = ~a;
    B        = b ^ 32'h5A5A_5A5A;
  endtask

  task automatic runMul(input string tag, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input logic [63:0] expRes,
                        input logic expOvf);
    int cycles;
    applyStimulus(1'b1, a, b);
    checkOutput({tag, "_busy_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_busy_ready"}, 64'(in_ready), 64'd0);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    checkOutput({tag, "_latency"}, 64'(cycles), 64'd32);
    checkOutput({tag, "_result"}, 64'(Result), expRes);
    checkOutput({tag, "_ovf"}, 64'(ovf), 64'(expOvf));
  endtask

  initial begin
    int leaks;
    total     = 0;
    bad       = 0;
    nrst      = 1'b0;
    Sel       = 1'b0;
    A         = '0;
    B         = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;

    #12;
    checkOutput("rst_result", 64'(Result), 64'd0);
    checkOutput("rst_ovf", 64'(ovf), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 32'd150, 32'd120);
    checkOutput("add1_valid", 64'(out_valid), 64'd1);
    checkOutput("add1_result", 64'(Result), 64'd270);
    checkOutput("add1_ovf", 64'(ovf), 64'd0);

    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1);
    checkOutput("add2_valid", 64'(out_valid), 64'd1);
    checkOutput("add2_result", 64'(Result), 64'h01_0000_0000);
    checkOutput("add2_ovf", 64'(ovf), 64'd0);

    @(posedge clk);
    #1;
    checkOutput("retire_valid", 64'(out_valid), 64'd0);
    checkOutput("retire_keep", 64'(Result), 64'h01_0000_0000);
    checkOutput("retire_ready", 64'(in_ready), 64'd1);

    runMul("mul_150x120", 32'd150, 32'd120, 64'd18000, 1'b0);
    runMul("mul_max_x1", 32'hFFFF_FFFF, 32'd1, 64'hFFFF_FFFF, 1'b0);
    runMul("mul_10x0", 32'd10, 32'd0, 64'd0, 1'b0);
    runMul("mul_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFE_0000_0001, 1'b1);

    out_ready = 1'b0;
    @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    checkOutput("arst_result", 64'(Result), 64'd0);
    checkOutput("arst_ovf", 64'(ovf), 64'd0);
    checkOutput("arst_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus(1'b0, 32'd7, 32'd8);
    checkOutput("bp_first", 64'(Result), 64'd15);
    for (int i = 0; i < 10; i++) begin
      Sel      = i[0];
      A        = 32'd99;
      B        = 32'd99;
      in_valid = i[0];
      @(posedge clk);
      #1;
      checkOutput($sformatf("bp_valid_%0d", i), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_result_%0d", i), 64'(Result), 64'd15);
      checkOutput($sformatf("bp_ready_%0d", i), 64'(in_ready), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'd10, 32'd10);
    checkOutput("bp_next_valid", 64'(out_valid), 64'd1);
    checkOutput("bp_next_result", 64'(Result), 64'd20);
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 32'd7, 32'd9);
    repeat (14) @(posedge clk);
    #3;
    nrst = 1'b0;
    #1;
    checkOutput("midmul_valid", 64'(out_valid), 64'd0);
    checkOutput("midmul_result", 64'(Result), 64'd0);
    @(negedge clk);
    nrst = 1'b1;
    leaks = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) leaks++;
    end
    checkOutput("midmul_no_result", 64'(leaks), 64'd0);
    runMul("mul_3x4", 32'd3, 32'd4, 64'd12, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not reach end, observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
